// File: rtl/alu_div_sequencer.sv
// Operand sequencer and result stage around the combinational divider.
// Collects dividend then divisor, registers quotient, guards divide-by-zero.
//
// Ports:
//   clk_i, rst_ni (sync, active low), clr_i (sync abort)
//   in_data_i/in_valid_i/in_ready_o    : operand byte stream
//   div_a_o/div_b_o -> divider, div_q_i <- divider quotient
//   out_q_o/out_div0_o/out_valid_o/out_ready_i : result port
module alu_div_sequencer #(
  parameter int unsigned          DATA_W = 8,
  parameter logic [DATA_W-1:0]    ZERO_Q = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] div_a_o,
  output logic [DATA_W-1:0] div_b_o,
  input  logic [DATA_W-1:0] div_q_i,
  output logic [DATA_W-1:0] out_q_o,
  output logic              out_div0_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              a_en;
  logic              b_en;
  logic              res_en;
  logic              valid_d;
  logic              b_zero;

  assign div_a_o = a_q;
  assign div_b_o = b_q;
  assign b_zero  = (b_q == '0);

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    a_en       = 1'b0;
    b_en       = 1'b0;
    res_en     = 1'b0;
    valid_d    = out_valid_o;
    case (state_q)
      S_A: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_en    = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          b_en    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_en  = 1'b1;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          state_d = S_A;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_A;
      end
    endcase
    // Abort overrides every transition; any byte offered now is dropped.
    if (clr_i) begin
      a_en    = 1'b0;
      b_en    = 1'b0;
      res_en  = 1'b0;
      valid_d = 1'b0;
      state_d = S_A;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      out_q_o     <= '0;
      out_div0_o  <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_o <= valid_d;
      if (a_en) a_q <= in_data_i;
      if (b_en) b_q <= in_data_i;
      // div_q_i is not looked at for a zero divisor.
      if (res_en) begin
        out_q_o    <= b_zero ? ZERO_Q : div_q_i;
        out_div0_o <= b_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed self-checking bench for alu_div_sequencer.
// Models the combinational divider with a garbage value on divide-by-zero.
module tb_alu_div_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] div_a;
  logic [7:0] div_b;
  logic [7:0] div_q;
  logic [7:0] out_q;
  logic       out_div0;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    div_q = 8'h5A;
    if (div_b != 8'd0) div_q = div_a / div_b;
  end

  alu_div_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .div_a_o     (div_a),
    .div_b_o     (div_b),
    .div_q_i     (div_q),
    .out_q_o     (out_q),
    .out_div0_o  (out_div0),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] q,
                         input logic z);
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk({tag, "_q"}, out_q, q);
    chk({tag, "_div0"}, {7'd0, out_div0}, {7'd0, z});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_data = 8'd0;
    in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_q", out_q, 8'd0);
    chk("rst_div0", {7'd0, out_div0}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_a", div_a, 8'd0);
    chk("rst_b", div_b, 8'd0);
    rst_n = 1'b1;

    // T1: 200/7, valid after one exec cycle, one cycle wide
    out_ready = 1'b1;
    push(8'd200);
    chk("t1_ready_b", {7'd0, in_ready}, 8'd1);
    chk("t1_a", div_a, 8'd200);
    push(8'd7);
    chk("t1_b", div_b, 8'd7);
    chk("t1_exec_ready", {7'd0, in_ready}, 8'd0);
    chk("t1_exec_valid", {7'd0, out_valid}, 8'd0);
    step();
    chk_res("t1", 8'd28, 1'b0);
    step();
    chk("t1_valid_drop", {7'd0, out_valid}, 8'd0);
    chk("t1_ready_back", {7'd0, in_ready}, 8'd1);

    // T2: 255/1 with byte 9 held offered through exec/out, then 9/3
    push(8'd255);
    in_valid = 1'b1; in_data = 8'd1;
    step();
    in_data = 8'd9;
    chk("t2_exec_ready", {7'd0, in_ready}, 8'd0);
    step();
    chk_res("t2a", 8'd255, 1'b0);
    chk("t2_out_ready", {7'd0, in_ready}, 8'd0);
    chk("t2_a_kept", div_a, 8'd255);
    step();
    chk("t2_a_ready", {7'd0, in_ready}, 8'd1);
    step();
    chk("t2_a9", div_a, 8'd9);
    in_data = 8'd3;
    step();
    in_valid = 1'b0;
    step();
    chk_res("t2b", 8'd3, 1'b0);
    step();

    // T3: divide by zero, then 8/2
    push(8'd5);
    push(8'd0);
    step();
    chk_res("t3a", 8'hFF, 1'b1);
    step();
    push(8'd8);
    push(8'd2);
    step();
    chk_res("t3b", 8'd4, 1'b0);
    step();

    // T4: backpressure for 5 cycles with refused input pulses
    out_ready = 1'b0;
    push(8'd100);
    push(8'd10);
    step();
    chk_res("t4", 8'd10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_data  = 8'd77;
      step();
      chk_res("t4_hold", 8'd10, 1'b0);
      chk("t4_blocked", {7'd0, in_ready}, 8'd0);
      chk("t4_a_kept", div_a, 8'd100);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t4_release", {7'd0, out_valid}, 8'd0);
    chk("t4_ready_back", {7'd0, in_ready}, 8'd1);
    chk("t4_b_kept", div_b, 8'd10);

    // T5: abort after dividend, offered byte dropped
    push(8'd50);
    chk("t5_a", div_a, 8'd50);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("t5_b_kept", div_b, 8'd10);
    chk("t5_a_kept", div_a, 8'd50);
    chk("t5_valid", {7'd0, out_valid}, 8'd0);
    push(8'd60);
    push(8'd6);
    step();
    chk_res("t5", 8'd10, 1'b0);
    step();

    // T6: reset while holding a result, then 0/4
    out_ready = 1'b0;
    push(8'd12);
    push(8'd4);
    step();
    chk_res("t6_pre", 8'd3, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", {7'd0, out_valid}, 8'd0);
    chk("t6_q", out_q, 8'd0);
    chk("t6_ready", {7'd0, in_ready}, 8'd1);
    chk("t6_a", div_a, 8'd0);
    out_ready = 1'b1;
    push(8'd0);
    push(8'd4);
    step();
    chk_res("t6", 8'd0, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
